// File: rtl/hazard_pkg.sv
// Shared slot type and availability helper for hazard_fwd_unit.
// Slot addresses are held at HZ_AW bits; narrower register files zero-extend.
package hazard_pkg;

  localparam int HZ_AW       = 8;
  localparam int FWD_REGFILE = 0;

  typedef struct packed {
    logic             valid;
    logic             wen;
    logic             is_load;
    logic             use_rs;
    logic             use_rt;
    logic [HZ_AW-1:0] rd;
    logic [HZ_AW-1:0] rs;
    logic [HZ_AW-1:0] rt;
  } slot_t;

  // Slot index at which a writer's result can first be forwarded.
  function automatic int fwd_avail(
    input logic is_load,
    input int   load_lat
  );
    return is_load ? 1 + load_lat : 1;
  endfunction

endpackage

// File: rtl/hazard_slot_match.sv
// Compares one source register against one in-flight writer slot.
// ready means the writer's result is forwardable at distance DIST.
module hazard_slot_match
  import hazard_pkg::*;
#(
  parameter int DIST     = 0,
  parameter int LOAD_LAT = 1
) (
  input  logic [HZ_AW-1:0] i_src,
  input  logic             i_use,
  input  logic             i_valid,
  input  logic             i_wen,
  input  logic             i_is_load,
  input  logic [HZ_AW-1:0] i_rd,
  output logic             hit,
  output logic             ready
);

  assign hit = i_use & i_valid & i_wen &
               (i_rd != '0) & (i_rd == i_src);

  assign ready = (DIST >= fwd_avail(i_is_load, LOAD_LAT));

endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use stall and EX forwarding control over a slot scoreboard.
// Define HAZ_STATS_EN to build the saturating stall_cnt counter.
module hazard_fwd_unit
  import hazard_pkg::*;
#(
  parameter  int REG_AW   = 5,
  parameter  int STAGES   = 3,
  parameter  int LOAD_LAT = 1,
  localparam int SELW     = $clog2(STAGES)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_wen,
  input  logic              id_is_load,
  input  logic              id_flush,
  input  logic              mem_stall,
  output logic              stall_if,
  output logic              bubble_ex,
  output logic [SELW-1:0]   ex_fwd_a,
  output logic [SELW-1:0]   ex_fwd_b,
  output logic [31:0]       stall_cnt
);

  slot_t             r_slot [STAGES];
  slot_t             w_id_slot;
  logic [STAGES-1:0] w_id_hit_a;
  logic [STAGES-1:0] w_id_rdy_a;
  logic [STAGES-1:0] w_id_hit_b;
  logic [STAGES-1:0] w_id_rdy_b;
  logic [STAGES-1:1] w_ex_hit_a;
  logic [STAGES-1:1] w_ex_rdy_a;
  logic [STAGES-1:1] w_ex_hit_b;
  logic [STAGES-1:1] w_ex_rdy_b;
  logic              w_load_use;
  logic [SELW-1:0]   w_fwd_a;
  logic [SELW-1:0]   w_fwd_b;

  always_comb begin
    w_id_slot         = '0;
    w_id_slot.valid   = 1'b1;
    w_id_slot.wen     = id_wen;
    w_id_slot.is_load = id_is_load;
    w_id_slot.use_rs  = id_use_rs;
    w_id_slot.use_rt  = id_use_rt;
    w_id_slot.rd      = HZ_AW'(id_rd);
    w_id_slot.rs      = HZ_AW'(id_rs);
    w_id_slot.rt      = HZ_AW'(id_rt);
  end

  // ID sees slot k one cycle before EX would, hence distance k+1.
  for (genvar k = 0; k < STAGES; k++) begin : g_slot
    hazard_slot_match #(
      .DIST     (k + 1),
      .LOAD_LAT (LOAD_LAT)
    ) u_id_a (
      .i_src     (w_id_slot.rs),
      .i_use     (id_use_rs),
      .i_valid   (r_slot[k].valid),
      .i_wen     (r_slot[k].wen),
      .i_is_load (r_slot[k].is_load),
      .i_rd      (r_slot[k].rd),
      .hit       (w_id_hit_a[k]),
      .ready     (w_id_rdy_a[k])
    );
    hazard_slot_match #(
      .DIST     (k + 1),
      .LOAD_LAT (LOAD_LAT)
    ) u_id_b (
      .i_src     (w_id_slot.rt),
      .i_use     (id_use_rt),
      .i_valid   (r_slot[k].valid),
      .i_wen     (r_slot[k].wen),
      .i_is_load (r_slot[k].is_load),
      .i_rd      (r_slot[k].rd),
      .hit       (w_id_hit_b[k]),
      .ready     (w_id_rdy_b[k])
    );
    if (k > 0) begin : g_fwd
      hazard_slot_match #(
        .DIST     (k),
        .LOAD_LAT (LOAD_LAT)
      ) u_ex_a (
        .i_src     (r_slot[0].rs),
        .i_use     (r_slot[0].use_rs),
        .i_valid   (r_slot[k].valid),
        .i_wen     (r_slot[k].wen),
        .i_is_load (r_slot[k].is_load),
        .i_rd      (r_slot[k].rd),
        .hit       (w_ex_hit_a[k]),
        .ready     (w_ex_rdy_a[k])
      );
      hazard_slot_match #(
        .DIST     (k),
        .LOAD_LAT (LOAD_LAT)
      ) u_ex_b (
        .i_src     (r_slot[0].rt),
        .i_use     (r_slot[0].use_rt),
        .i_valid   (r_slot[k].valid),
        .i_wen     (r_slot[k].wen),
        .i_is_load (r_slot[k].is_load),
        .i_rd      (r_slot[k].rd),
        .hit       (w_ex_hit_b[k]),
        .ready     (w_ex_rdy_b[k])
      );
    end
  end

  assign w_load_use = id_valid & ~id_flush &
                      ((|(w_id_hit_a & ~w_id_rdy_a)) |
                       (|(w_id_hit_b & ~w_id_rdy_b)));

  assign stall_if  = w_load_use | mem_stall;
  assign bubble_ex = w_load_use & ~mem_stall;

  // Walk oldest to youngest so the youngest ready writer wins.
  always_comb begin
    w_fwd_a = SELW'(FWD_REGFILE);
    w_fwd_b = SELW'(FWD_REGFILE);
    for (int k = STAGES - 1; k >= 1; k--) begin
      if (w_ex_hit_a[k] && w_ex_rdy_a[k]) w_fwd_a = SELW'(k);
      if (w_ex_hit_b[k] && w_ex_rdy_b[k]) w_fwd_b = SELW'(k);
    end
  end

  assign ex_fwd_a = w_fwd_a;
  assign ex_fwd_b = w_fwd_b;

  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int k = 0; k < STAGES; k++) r_slot[k] <= '0;
    end else if (!mem_stall) begin
      for (int k = 1; k < STAGES; k++) r_slot[k] <= r_slot[k-1];
      if (id_valid && !id_flush && !w_load_use) r_slot[0] <= w_id_slot;
      else r_slot[0] <= '0;
    end
  end

`ifdef HAZ_STATS_EN
  logic [31:0] r_stall_cnt;

  always_ff @(posedge clk) begin
    if (!reset) r_stall_cnt <= '0;
    else if (bubble_ex && (r_stall_cnt != '1))
      r_stall_cnt <= r_stall_cnt + 32'd1;
  end

  assign stall_cnt = r_stall_cnt;
`else
  assign stall_cnt = '0;
`endif

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (reset) begin
      assert (((w_ex_hit_a & ~w_ex_rdy_a) |
               (w_ex_hit_b & ~w_ex_rdy_b)) == '0)
        else $error("hazard_fwd_unit: EX source not forwardable");
    end
  end
`endif

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Bench for hazard_fwd_unit: directed pipeline scenarios plus random
// traffic against a timestamp-based model of two configurations.
module tb_hazard_fwd_unit;

`ifdef HAZ_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        id_valid, id_use_rs, id_use_rt;
  logic        id_wen, id_is_load, id_flush, mem_stall;
  logic [4:0]  id_rs, id_rt, id_rd;
  logic        s1_stall, s1_bub, s2_stall, s2_bub;
  logic [1:0]  s1_fa, s1_fb, s2_fa, s2_fb;
  logic [31:0] s1_cnt, s2_cnt;
  logic [5:0]  o1, o2;
  int          checks = 0;
  int          fails = 0;

  assign o1 = {s1_stall, s1_bub, s1_fa, s1_fb};
  assign o2 = {s2_stall, s2_bub, s2_fa, s2_fb};

  always #5 clk = ~clk;

  hazard_fwd_unit u_dut1 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_rd(id_rd), .id_wen(id_wen),
    .id_is_load(id_is_load), .id_flush(id_flush),
    .mem_stall(mem_stall), .stall_if(s1_stall),
    .bubble_ex(s1_bub), .ex_fwd_a(s1_fa), .ex_fwd_b(s1_fb),
    .stall_cnt(s1_cnt)
  );

  hazard_fwd_unit #(.STAGES(4), .LOAD_LAT(2)) u_dut2 (
    .clk(clk), .reset(reset), .id_valid(id_valid),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs),
    .id_use_rt(id_use_rt), .id_rd(id_rd), .id_wen(id_wen),
    .id_is_load(id_is_load), .id_flush(id_flush),
    .mem_stall(mem_stall), .stall_if(s2_stall),
    .bubble_ex(s2_bub), .ex_fwd_a(s2_fa), .ex_fwd_b(s2_fb),
    .stall_cnt(s2_cnt)
  );

  // Model: each config logs instructions by the pipeline time at which
  // they entered EX; an entry's distance from EX is now - entry time.
  typedef struct packed {
    logic       vld, wen, ld, urs, urt;
    logic [4:0] rd, rs, rt;
  } ins_t;

  ins_t        ring [2][16];
  int          mt [2];
  logic [31:0] mcnt [2];

  function automatic int st(input int c);
    return (c == 0) ? 3 : 4;
  endfunction

  function automatic int avl(input int c, input logic ld);
    return ld ? 1 + ((c == 0) ? 1 : 2) : 1;
  endfunction

  function automatic logic m_lu(input int c);
    ins_t e;
    if (!id_valid || id_flush) return 1'b0;
    for (int p = 0; p < st(c); p++) begin
      e = ring[c][(mt[c] - p) & 15];
      if (e.vld && e.wen && e.rd != 0 && p + 1 < avl(c, e.ld) &&
          ((id_use_rs && e.rd == id_rs) ||
           (id_use_rt && e.rd == id_rt)))
        return 1'b1;
    end
    return 1'b0;
  endfunction

  function automatic int m_fwd(input int c, input logic b);
    ins_t x, e;
    logic u;
    logic [4:0] r;
    x = ring[c][mt[c] & 15];
    u = b ? x.urt : x.urs;
    r = b ? x.rt : x.rs;
    if (!x.vld || !u) return 0;
    for (int p = 1; p < st(c); p++) begin
      e = ring[c][(mt[c] - p) & 15];
      if (e.vld && e.wen && e.rd != 0 && e.rd == r &&
          p >= avl(c, e.ld))
        return p;
    end
    return 0;
  endfunction

  function automatic logic [31:0] ecnt(input int c);
    return STATS ? mcnt[c] : 32'd0;
  endfunction

  function automatic logic [5:0] m_out(input int c);
    logic lu;
    lu = m_lu(c);
    return {lu | mem_stall, lu & ~mem_stall,
            2'(m_fwd(c, 1'b0)), 2'(m_fwd(c, 1'b1))};
  endfunction

  task automatic m_clock();
    logic lu;
    ins_t n;
    for (int c = 0; c < 2; c++) begin
      if (!reset) begin
        mt[c] = 0;
        mcnt[c] = 32'd0;
        for (int i = 0; i < 16; i++) ring[c][i] = '0;
      end else if (!mem_stall) begin
        lu = m_lu(c);
        if (lu && mcnt[c] != 32'hFFFF_FFFF) mcnt[c] = mcnt[c] + 1;
        n = '0;
        if (id_valid && !id_flush && !lu) begin
          n.vld = 1'b1; n.wen = id_wen; n.ld = id_is_load;
          n.urs = id_use_rs; n.urt = id_use_rt;
          n.rd = id_rd; n.rs = id_rs; n.rt = id_rt;
        end
        mt[c] = mt[c] + 1;
        ring[c][mt[c] & 15] = n;
      end
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_clock();
    #1;
  endtask

  task automatic set_id(
    input logic v, input logic [4:0] rs, input logic [4:0] rt,
    input logic urs, input logic urt, input logic [4:0] rd,
    input logic wen, input logic ld
  );
    id_valid = v; id_rs = rs; id_rt = rt;
    id_use_rs = urs; id_use_rt = urt; id_rd = rd;
    id_wen = wen; id_is_load = ld;
    id_flush = 1'b0; mem_stall = 1'b0;
  endtask

  task automatic idle();
    set_id(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    idle();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    #1;
    checks++;
    if (o1 !== 6'b0) begin
      fails++; $display("FAIL reset_d1: got %b want %b", o1, 6'b0);
    end
    checks++;
    if (o2 !== 6'b0) begin
      fails++; $display("FAIL reset_d2: got %b want %b", o2, 6'b0);
    end
    checks++;
    if ({s1_cnt, s2_cnt} !== 64'd0) begin
      fails++; $display("FAIL reset_cnt: got %0d/%0d want 0", s1_cnt, s2_cnt);
    end
  endtask

  task automatic test_alu_fwd();
    do_reset();
    set_id(1, 1, 2, 1, 1, 3, 1, 0);
    #1;
    checks++;
    if (o1 !== 6'b0) begin
      fails++; $display("FAIL t1_add: got %b want %b", o1, 6'b0);
    end
    tick();
    set_id(1, 3, 5, 1, 1, 4, 1, 0);
    #1;
    checks++;
    if (o1 !== 6'b0) begin
      fails++; $display("FAIL t1_sub_nostall: got %b want %b", o1, 6'b0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (o1 !== 6'b00_01_00) begin
      fails++; $display("FAIL t1_fwd: got %b want %b", o1, 6'b00_01_00);
    end
  endtask

  task automatic test_load_use();
    do_reset();
    set_id(1, 1, 0, 1, 0, 3, 1, 1);
    tick();
    set_id(1, 3, 3, 1, 1, 4, 1, 0);
    #1;
    checks++;
    if (o1 !== 6'b11_00_00) begin
      fails++; $display("FAIL t2_stall: got %b want %b", o1, 6'b11_00_00);
    end
    tick();
    checks++;
    if (o1 !== 6'b0) begin
      fails++; $display("FAIL t2_release: got %b want %b", o1, 6'b0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (o1 !== 6'b00_10_10) begin
      fails++; $display("FAIL t2_fwd: got %b want %b", o1, 6'b00_10_10);
    end
    checks++;
    if (s1_cnt !== 32'(STATS)) begin
      fails++; $display("FAIL t2_cnt: got %0d want %0d", s1_cnt, STATS);
    end
  endtask

  task automatic test_long_load();
    do_reset();
    set_id(1, 1, 0, 1, 0, 7, 1, 1);
    tick();
    set_id(1, 7, 7, 1, 1, 8, 1, 0);
    for (int i = 0; i < 2; i++) begin
      #1;
      checks++;
      if (o2 !== 6'b11_00_00) begin
        fails++; $display("FAIL t3_stall%0d: got %b want %b", i, o2, 6'b11_00_00);
      end
      tick();
    end
    checks++;
    if (o2 !== 6'b0) begin
      fails++; $display("FAIL t3_release: got %b want %b", o2, 6'b0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (o2 !== 6'b00_11_11) begin
      fails++; $display("FAIL t3_fwd: got %b want %b", o2, 6'b00_11_11);
    end
  endtask

  task automatic test_youngest();
    do_reset();
    set_id(1, 1, 1, 1, 1, 2, 1, 0);
    tick();
    set_id(1, 2, 2, 1, 1, 2, 1, 0);
    tick();
    set_id(1, 2, 0, 1, 1, 5, 1, 0);
    #1;
    checks++;
    if (o1 !== 6'b00_01_01) begin
      fails++; $display("FAIL t4_mid: got %b want %b", o1, 6'b00_01_01);
    end
    tick();
    idle();
    #1;
    checks++;
    if (o1 !== 6'b00_01_00) begin
      fails++; $display("FAIL t4_young: got %b want %b", o1, 6'b00_01_00);
    end
    do_reset();
    set_id(1, 1, 1, 1, 1, 0, 1, 1);
    tick();
    set_id(1, 0, 0, 1, 1, 6, 1, 0);
    #1;
    checks++;
    if (o1 !== 6'b0) begin
      fails++; $display("FAIL t4_r0_stall: got %b want %b", o1, 6'b0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (o1 !== 6'b0) begin
      fails++; $display("FAIL t4_r0_fwd: got %b want %b", o1, 6'b0);
    end
  endtask

  task automatic test_mem_stall();
    do_reset();
    set_id(1, 1, 0, 1, 0, 3, 1, 1);
    tick();
    set_id(1, 3, 0, 1, 0, 4, 1, 0);
    mem_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (o1 !== 6'b10_00_00) begin
        fails++; $display("FAIL t5_frozen%0d: got %b want %b", i, o1, 6'b10_00_00);
      end
      tick();
    end
    mem_stall = 1'b0;
    #1;
    checks++;
    if (o1 !== 6'b11_00_00) begin
      fails++; $display("FAIL t5_bubble: got %b want %b", o1, 6'b11_00_00);
    end
    tick();
    checks++;
    if (o1 !== 6'b0) begin
      fails++; $display("FAIL t5_release: got %b want %b", o1, 6'b0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (o1 !== 6'b00_10_00) begin
      fails++; $display("FAIL t5_fwd: got %b want %b", o1, 6'b00_10_00);
    end
    checks++;
    if (s1_cnt !== 32'(STATS)) begin
      fails++; $display("FAIL t5_cnt: got %0d want %0d", s1_cnt, STATS);
    end
  endtask

  task automatic test_flush();
    do_reset();
    set_id(1, 1, 0, 1, 0, 3, 1, 1);
    tick();
    set_id(1, 3, 3, 1, 1, 4, 1, 0);
    id_flush = 1'b1;
    #1;
    checks++;
    if (o1 !== 6'b0) begin
      fails++; $display("FAIL flush_nostall: got %b want %b", o1, 6'b0);
    end
    tick();
    idle();
    #1;
    checks++;
    if (o1 !== 6'b0) begin
      fails++; $display("FAIL flush_dropped: got %b want %b", o1, 6'b0);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_id(1, 1, 0, 1, 0, 3, 1, 1);
    tick();
    set_id(1, 3, 3, 1, 1, 4, 1, 0);
    #1;
    checks++;
    if (o1 !== 6'b11_00_00) begin
      fails++; $display("FAIL t6_pre: got %b want %b", o1, 6'b11_00_00);
    end
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    checks++;
    if ({o1, o2} !== 12'b0) begin
      fails++; $display("FAIL t6_out: got %b/%b want 0", o1, o2);
    end
    checks++;
    if ({s1_cnt, s2_cnt} !== 64'd0) begin
      fails++; $display("FAIL t6_cnt: got %0d/%0d want 0", s1_cnt, s2_cnt);
    end
  endtask

  task automatic test_random();
    logic [5:0] e1, e2;
    do_reset();
    for (int i = 0; i < 400; i++) begin
      id_valid   = ($urandom_range(0, 3) != 0);
      id_rs      = 5'($urandom_range(0, 3));
      id_rt      = 5'($urandom_range(0, 3));
      id_rd      = 5'($urandom_range(0, 3));
      id_use_rs  = 1'($urandom_range(0, 1));
      id_use_rt  = 1'($urandom_range(0, 1));
      id_wen     = ($urandom_range(0, 3) != 0);
      id_is_load = ($urandom_range(0, 2) == 0);
      id_flush   = ($urandom_range(0, 7) == 0);
      mem_stall  = ($urandom_range(0, 5) == 0);
      reset      = ($urandom_range(0, 99) != 0);
      #1;
      e1 = m_out(0);
      e2 = m_out(1);
      checks++;
      if (o1 !== e1) begin
        fails++; $display("FAIL rnd_d1 cyc %0d: got %b want %b", i, o1, e1);
      end
      checks++;
      if (o2 !== e2) begin
        fails++; $display("FAIL rnd_d2 cyc %0d: got %b want %b", i, o2, e2);
      end
      checks++;
      if ({s1_cnt, s2_cnt} !== {ecnt(0), ecnt(1)}) begin
        fails++;
        $display("FAIL rnd_cnt cyc %0d: got %0d/%0d want %0d/%0d",
                 i, s1_cnt, s2_cnt, ecnt(0), ecnt(1));
      end
      tick();
    end
    reset = 1'b1;
  endtask

  initial begin
    idle();
    test_reset();
    test_alu_fwd();
    test_load_use();
    test_long_load();
    test_youngest();
    test_mem_stall();
    test_flush();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
